dist_min_search: RTL

//  Initiator for dist_calc: streams candidate 2x2 complex matrices against a fixed target,

---
 rtl/dist_min_search_pkg.sv | 20 ++
 rtl/dist_min_search_tracker.sv | 35 +++
 rtl/dist_min_search.sv | 110 +++++++++++
 3 files changed

// File: rtl/dist_min_search_pkg.sv
// dist_min_search_pkg: shared matrix/distance types, constants and FSM states for the minimum-distance search
package dist_min_search_pkg;
  localparam int NUMBER_BITS = 37;
  localparam int DIST2_BITS = 2 * (NUMBER_BITS + 3) + 1;
  typedef struct packed {
    logic signed [NUMBER_BITS-1:0] re;
    logic signed [NUMBER_BITS-1:0] im;
  } complex_t;
  typedef complex_t [0:1][0:1] matrix2_t;
  typedef logic signed [DIST2_BITS-1:0] dist2_t;
  localparam dist2_t DIST2_MAX = {1'b0, {(DIST2_BITS-1){1'b1}}};
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_COMPARE,
    S_DONE
  } state_t;
endpackage

// File: rtl/dist_min_search_tracker.sv
// dist_min_tracker: holds the best (smallest signed dist2) candidate, earliest index wins ties
module dist_min_tracker
  import dist_min_search_pkg::*;
#(
  parameter int IDX_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                cmp,
  input  logic [IDX_BITS-1:0] idx,
  input  dist2_t              dist2,
  output logic [IDX_BITS-1:0] best_idx,
  output dist2_t              best_dist2
);
  logic first;
  logic commit;
  // the first candidate after a clear is taken unconditionally; later ones only on a strict improvement
  always_comb commit = cmp & (first | (dist2 < best_dist2));
  // best-so-far register with clear on a new search
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      first      <= 1'b1;
      best_idx   <= '0;
      best_dist2 <= DIST2_MAX;
    end else if (clear) begin
      first      <= 1'b1;
      best_idx   <= '0;
      best_dist2 <= DIST2_MAX;
    end else if (commit) begin
      first      <= 1'b0;
      best_idx   <= idx;
      best_dist2 <= dist2;
    end
endmodule

// File: rtl/dist_min_search.sv
// dist_min_search: streams candidates to dist_calc one job at a time and tracks the closest one
module dist_min_search
  import dist_min_search_pkg::*;
#(
  parameter int IDX_BITS = 8,
  parameter int TIMEOUT  = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  matrix2_t            mtx_target,
  input  matrix2_t            cand_mtx,
  input  logic                cand_valid,
  input  logic                cand_last,
  output logic                cand_ready,
  output matrix2_t            calc_mtx_a,
  output matrix2_t            calc_mtx_b,
  output logic                calc_ready,
  input  dist2_t              calc_dist2,
  input  logic                calc_done,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [IDX_BITS-1:0] best_idx,
  output dist2_t              best_dist2,
  output logic [IDX_BITS:0]   cand_count
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [IDX_BITS-1:0] IDX_MAX = '1;
  state_t state, state_n;
  logic last_q;
  dist2_t dist_q;
  logic [IDX_BITS-1:0] idx;
  logic [TW-1:0] timer;
  logic accept, take, hit, expire, ovf;
  // handshake and transition conditions
  always_comb begin
    accept = (state == S_IDLE) & start;
    take   = (state == S_FETCH) & cand_valid;
    hit    = (state == S_WAIT) & calc_done;
    expire = (state == S_WAIT) & ~calc_done & (timer == TW'(TIMEOUT));
    ovf    = (idx == IDX_MAX) & ~last_q;
  end
  // next-state logic; calc_done is only looked at in WAIT
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:    state_n = accept ? S_FETCH : S_IDLE;
      S_FETCH:   state_n = take ? S_ISSUE : S_FETCH;
      S_ISSUE:   state_n = S_WAIT;
      S_WAIT:    state_n = hit ? S_COMPARE : expire ? S_DONE : S_WAIT;
      S_COMPARE: state_n = (last_q | (idx == IDX_MAX)) ? S_DONE : S_FETCH;
      S_DONE:    state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end
  // decoded outputs
  always_comb begin
    cand_ready = state == S_FETCH;
    calc_ready = state == S_ISSUE;
    busy       = state != S_IDLE;
    done       = state == S_DONE;
  end
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_IDLE;
    else state <= state_n;
  // datapath: operand latches, wait timer, result latch, counters and sticky error
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      calc_mtx_a <= '0;
      calc_mtx_b <= '0;
      last_q     <= 1'b0;
      dist_q     <= '0;
      idx        <= '0;
      timer      <= '0;
      cand_count <= '0;
      error      <= 1'b0;
    end else begin
      if (accept) begin
        calc_mtx_a <= mtx_target;
        idx        <= '0;
        cand_count <= '0;
        error      <= 1'b0;
      end
      if (take) begin
        calc_mtx_b <= cand_mtx;
        last_q     <= cand_last;
      end
      if (state == S_ISSUE) timer <= TW'(1);
      else if (state == S_WAIT) timer <= timer + TW'(1);
      if (hit) dist_q <= calc_dist2;
      if (state == S_COMPARE) begin
        cand_count <= cand_count + (IDX_BITS+1)'(1);
        idx        <= idx + IDX_BITS'(1);
        if (ovf) error <= 1'b1;
      end
      if (expire) error <= 1'b1;
    end
  dist_min_tracker #(.IDX_BITS(IDX_BITS)) u_tracker (
    .clk       (clk),
    .reset     (reset),
    .clear     (accept),
    .cmp       (state == S_COMPARE),
    .idx       (idx),
    .dist2     (dist_q),
    .best_idx  (best_idx),
    .best_dist2(best_dist2)
  );
endmodule
